// File: rtl/adder_bcd.sv
// Single-digit BCD adder: registered sum of two BCD digits with a tens carry
// digit and an error flag for non-BCD operands.
module adder_bcd (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  output logic [3:0] out0,
  output logic [3:0] out1,
  output logic       flag,
  output logic       out_valid
);

  logic [4:0] sum;
  logic       op_err;
  logic [3:0] nxt_out0;
  logic [3:0] nxt_out1;
  logic       nxt_flag;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    nxt_out0 = '0;
    nxt_out1 = '0;
    nxt_flag = 1'b0;
    // Five bits so 15+15 cannot wrap; the error itself is judged on the operands.
    sum      = {1'b0, in0} + {1'b0, in1};
    op_err   = (in0 > 4'd9) || (in1 > 4'd9);

    if (op_err) begin
      nxt_flag = 1'b1;
    end else if (sum >= 5'd10) begin
      nxt_out1 = 4'd1;
      nxt_out0 = 4'(sum - 5'd10);
    end else begin
      nxt_out0 = sum[3:0];
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0      <= '0;
      out1      <= '0;
      flag      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out0 <= nxt_out0;
        out1 <= nxt_out1;
        flag <= nxt_flag;
      end
    end
  end

endmodule

// File: tb/tb_adder_bcd.sv
// Self-checking bench for adder_bcd: directed cases, an exhaustive 0-15 sweep,
// hold/reset behaviour and randomized traffic against an arithmetic model.
module tb_adder_bcd;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in0;
  logic [3:0] in1;
  logic [3:0] out0;
  logic [3:0] out1;
  logic       flag;
  logic       out_valid;

  int passed = 0;
  int total  = 0;

  // Model of the registered outputs
  logic [3:0] exp_out0  = '0;
  logic [3:0] exp_out1  = '0;
  logic       exp_flag  = 1'b0;
  logic       exp_valid = 1'b0;

  adder_bcd dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in0       (in0),
    .in1       (in1),
    .out0      (out0),
    .out1      (out1),
    .flag      (flag),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out0"},      out0,             exp_out0);
    check({tag, ".out1"},      out1,             exp_out1);
    check({tag, ".flag"},      {3'b0, flag},     {3'b0, exp_flag});
    check({tag, ".out_valid"}, {3'b0, out_valid}, {3'b0, exp_valid});
  endtask

  // Decimal arithmetic straight from the digit rules
  task automatic model(input logic v, input int a, input int b);
    exp_valid = v;
    if (v) begin
      if (a > 9 || b > 9) begin
        exp_flag = 1'b1;
        exp_out1 = 4'd0;
        exp_out0 = 4'd0;
      end else begin
        exp_flag = 1'b0;
        exp_out1 = 4'((a + b) / 10);
        exp_out0 = 4'((a + b) % 10);
      end
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge
  task automatic step(input logic v, input int a, input int b, input string tag);
    @(negedge clk);
    in_valid = v;
    in0      = 4'(a);
    in1      = 4'(b);
    @(posedge clk);
    model(v, a, b);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in0      = '0;
    in1      = '0;
    #1;
    check_all("reset");

    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 4, 5,   "4+5");
    step(1'b1, 7, 8,   "7+8");
    step(1'b1, 9, 9,   "9+9");
    step(1'b1, 0, 0,   "0+0");
    step(1'b1, 10, 3,  "10+3");
    step(1'b1, 15, 15, "15+15");
    step(1'b1, 3, 12,  "3+12");

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        step(1'b1, a, b, $sformatf("sweep %0d+%0d", a, b));

    step(1'b1, 6, 7, "6+7");
    for (int i = 0; i < 3; i++)
      step(1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           $sformatf("hold%0d", i));

    // Reset asserted between edges must clear outputs without a clock
    @(negedge clk);
    in_valid = 1'b1;
    in0      = 4'd9;
    in1      = 4'd8;
    #2;
    rst_n     = 1'b0;
    exp_out0  = '0;
    exp_out1  = '0;
    exp_flag  = 1'b0;
    exp_valid = 1'b0;
    #1;
    check_all("async_reset");
    @(posedge clk);
    #1;
    check_all("in_reset");

    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in0      = 4'd2;
    in1      = 4'd9;
    @(posedge clk);
    model(1'b1, 2, 9);
    #1;
    check_all("release 2+9");

    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), $sformatf("rand%0d", i));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adder_bcd.md
ADDER_BCD -- requirements
Module: adder_bcd

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  qualifies in0/in1 for capture on the current rising edge.
REQ-005 in0  input  4  first BCD operand digit, legal range 0-9.
REQ-006 in1  input  4  second BCD operand digit, legal range 0-9.
REQ-007 out0  output  4  registered BCD units digit of the sum.
REQ-008 out1  output  4  registered BCD tens digit of the sum; bits [3:1] always 0.
REQ-009 flag  output  1  registered error flag; 1 when either captured operand was non-BCD (>9).
REQ-010 out_valid  output  1  high for one cycle when out0/out1/flag hold a new result.

Function
REQ-011 On a rising clk edge with in_valid=1, the block SHALL capture in0/in1 and compute the result; out0/out1/flag/out_valid SHALL update at that same edge (latency 1 cycle from input sample to registered output).
REQ-012 Legal case (in0<=9 and in1<=9): binary sum S = in0+in1 (range 0-18); out1 SHALL be 1 if S>=10, else 0; out0 SHALL be S-10 if S>=10, else S; flag SHALL be 0.
REQ-013 Any other combination of in0/in1 not covered by REQ-012 SHALL NOT produce a legal-case result.
REQ-014 Error case (in0>9 or in1>9, including both): flag SHALL be 1, out0 SHALL be 0, out1 SHALL be 0.
REQ-015 Edges with in_valid=1 SHALL set out_valid=1 for the following cycle; edges with in_valid=0 SHALL clear out_valid to 0.
REQ-016 When in_valid=0, out0/out1/flag SHALL hold their previous values.
REQ-017 Back-to-back in_valid=1 on consecutive cycles SHALL produce one result per cycle, with no bubbles and no stall.
REQ-018 There is no backpressure; results not consumed during their out_valid cycle are overwritten by the next accepted operand pair.
REQ-019 out0 SHALL never exceed 9 and out1 SHALL never exceed 1 under any input, including X-free non-BCD inputs 10-15.
REQ-020 The arithmetic SHALL use at least 5 bits internally so that the sum 15+15=30 does not wrap before error detection; error detection is based on the operands, not the sum.

Reset
REQ-021 While rst_n=0, out0, out1, flag and out_valid SHALL be 0, applied immediately without waiting for clk.
REQ-022 Assertion of rst_n mid-operation SHALL discard any result in flight; the first out_valid after reset release SHALL correspond to the first in_valid=1 edge sampled with rst_n=1.
REQ-023 Deassertion of rst_n is synchronous to clk from the design's perspective; inputs on the first edge after release SHALL be processed normally.

Verification
REQ-024 in0=4, in1=5, in_valid=1 -> next cycle: out1=0, out0=9, flag=0, out_valid=1.
REQ-025 in0=7, in1=8 -> out1=1, out0=5, flag=0; in0=9, in1=9 -> out1=1, out0=8, flag=0; in0=0, in1=0 -> out1=0, out0=0, flag=0.
REQ-026 in0=10, in1=3 -> flag=1, out1=0, out0=0; in0=15, in1=15 -> flag=1, out1=0, out0=0.
REQ-027 Exhaustive sweep: in0 and in1 each over 0-15 with in_valid=1 every cycle -> each result matches REQ-012/REQ-014 exactly one cycle later, with out_valid continuously 1.
REQ-028 Load 6+7 (result out1=1, out0=3), then hold in_valid=0 for 3 cycles -> outputs stay 1/3 and out_valid=0; then assert rst_n=0 between clock edges -> all outputs 0 immediately.
REQ-029 Release reset with in_valid=1, in0=2, in1=9 on the first edge -> out1=1, out0=1, flag=0, out_valid=1 one cycle later.
